// File: rtl/pwm_pkg.sv
// Shared PWM timebase constants and capture FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_pkg;

   // Prescaler terminal count shared with the PWM generator (one tick every CLK_DIV+1 clks).
   localparam int CLK_DIV_DEF = 12;
   // Ticks per PWM period, and width of the duty code.
   localparam int PWM_STEPS   = 256;
   localparam int DUTY_W      = 8;

   typedef enum logic {
      WAIT,
      MEASURE
   } cap_state_e;

endpackage

// File: rtl/pwm_capture_sync.sv
// Synchronizes the asynchronous PWM pin and flags its rising edges.
// Latency: a pin edge shows on in_s_o after SYNC_STAGES clks; rise_o is high for that one clk.
// Backpressure: none; free-running every clk.
//
// Ports:
//   clk, rst_n  system clock, async active-low reset
//   pwm_i       raw asynchronous PWM pin
//   in_s_o      synchronized level
//   rise_o      one-clk pulse on a synchronized 0->1 transition
module pwm_in_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pwm_i,
   output logic in_s_o,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   in_d_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         in_d_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
         in_d_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign in_s_o = sync_q[SYNC_STAGES-1];
   assign rise_o = in_s_o & ~in_d_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM duty over one 256-tick window started at a rising edge; reports static levels on timeout.
// Latency: report lands 256*(CLK_DIV+1) clks after the window-opening rise; duty_valid is a one-clk pulse.
// Backpressure: none; reports are fire-and-forget, en low aborts any window in progress.
//
// Ports:
//   clk, rst_n  system clock, async active-low reset
//   en          capture enable; low parks the FSM in WAIT with counters cleared
//   pwm_in      asynchronous PWM input
//   duty_out    last duty code (0x00 always low, 0xFF always high, N = N/256 high)
//   duty_valid  one-clk pulse coincident with a duty_out update
//   no_edge     1 when the last report came from the no-edge timeout
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int CLK_DIV         = CLK_DIV_DEF,
   parameter int SYNC_STAGES     = 2,
   parameter int TIMEOUT_WINDOWS = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              pwm_in,
   output logic [DUTY_W-1:0] duty_out,
   output logic              duty_valid,
   output logic              no_edge
);

   localparam int PW       = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
   localparam int CW       = $clog2(PWM_STEPS) + 1;
   localparam int TO_LIMIT = TIMEOUT_WINDOWS * PWM_STEPS;
   localparam int TW       = $clog2(TO_LIMIT) + 1;

   localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_DIV);
   localparam logic [CW-1:0] STEPS_V    = CW'(PWM_STEPS);
   localparam logic [TW-1:0] TO_LIMIT_V = TW'(TO_LIMIT);

   cap_state_e        state_q;
   logic [PW-1:0]     presc_q, presc_eff, presc_d;
   logic [CW-1:0]     tick_cnt_q;
   logic [CW-1:0]     high_cnt_q;
   logic [TW-1:0]     timeout_q;
   logic [DUTY_W-1:0] duty_q;
   logic              duty_valid_q;
   logic              no_edge_q;

   logic in_s, rise;
   logic tick_raw, tick, win_end, win_start;

   pwm_in_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .pwm_i  (pwm_in),
      .in_s_o (in_s),
      .rise_o (rise)
   );

   // A window starting this cycle treats the prescaler as already 0, so the
   // opening cycle is itself sample k=0 and later samples fall every CLK_DIV+1 clks.
   assign tick_raw  = (presc_q == '0);
   assign win_end   = (state_q == MEASURE) && tick_raw && (tick_cnt_q == STEPS_V);
   assign win_start = rise && ((state_q == WAIT) || win_end);
   assign presc_eff = win_start ? '0 : presc_q;
   assign tick      = (presc_eff == '0);
   assign presc_d   = (presc_eff == PRESC_MAX) ? '0 : presc_eff + PW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= WAIT;
         presc_q      <= '0;
         tick_cnt_q   <= '0;
         high_cnt_q   <= '0;
         timeout_q    <= '0;
         duty_q       <= '0;
         duty_valid_q <= 1'b0;
         no_edge_q    <= 1'b0;
      end else if (!en) begin
         state_q      <= WAIT;
         presc_q      <= '0;
         tick_cnt_q   <= '0;
         high_cnt_q   <= '0;
         timeout_q    <= '0;
         duty_valid_q <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         duty_valid_q <= 1'b0;
         case (state_q)
            WAIT: begin
               if (rise) begin
                  // Opening sample is taken now; in_s is high by definition of rise.
                  state_q    <= MEASURE;
                  tick_cnt_q <= CW'(1);
                  high_cnt_q <= CW'(in_s);
                  timeout_q  <= '0;
               end else if (timeout_q == TO_LIMIT_V) begin
                  duty_q       <= in_s ? {DUTY_W{1'b1}} : {DUTY_W{1'b0}};
                  no_edge_q    <= 1'b1;
                  duty_valid_q <= 1'b1;
                  timeout_q    <= '0;
               end else if (tick) begin
                  timeout_q <= timeout_q + TW'(1);
               end
            end
            MEASURE: begin
               if (win_end) begin
                  // 256 high samples cannot be coded in 8 bits; saturate to always-high.
                  duty_q       <= (high_cnt_q == STEPS_V) ? {DUTY_W{1'b1}}
                                                          : high_cnt_q[DUTY_W-1:0];
                  no_edge_q    <= 1'b0;
                  duty_valid_q <= 1'b1;
                  if (rise) begin
                     // Back-to-back: this edge opens the next window with no gap.
                     tick_cnt_q <= CW'(1);
                     high_cnt_q <= CW'(in_s);
                  end else begin
                     state_q    <= WAIT;
                     tick_cnt_q <= '0;
                     high_cnt_q <= '0;
                     timeout_q  <= '0;
                  end
               end else if (tick) begin
                  tick_cnt_q <= tick_cnt_q + CW'(1);
                  high_cnt_q <= high_cnt_q + CW'(in_s);
               end
            end
            default: state_q <= WAIT;
         endcase
      end
   end

   assign duty_out   = duty_q;
   assign duty_valid = duty_valid_q;
   assign no_edge    = no_edge_q;

endmodule
